bhistoryresolveunit: RTL and testbench

//  Owns the global history register (GHR) and the perceptron weight table that the B-branch predictor reads.

---
 rtl/bhistoryresolveunit.sv | 188 ++++++++++++++++++
 tb/tb_bhistoryresolveunit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bhistoryresolveunit.sv
// B-branch history/resolve unit: owns the GHR and the perceptron weight table, retires entries in order, flushes on mispredict.
// Build option WEIGHT_INIT_SWEEP_EN: clear the weight table one row per cycle after reset instead of clearing it in reset.
module bhistoryresolveunit #(
    parameter int GHR_DEPTH = 20,
    parameter int WT_ROWS   = 228,
    parameter int WT_ROW_W  = 72
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_predValid,
    input  logic [2:0]                    i_passBNum_3,
    input  logic [131:0]                  i_newGHREntry_132,
    input  logic [7:0]                    i_errWeightPos_8,
    input  logic [WT_ROW_W-1:0]           i_newWeights_72,
    input  logic                          i_resValid,
    input  logic                          i_resTaken,
    input  logic [31:0]                   i_resTarget_32,
    input  logic [31:0]                   i_resFallPC_32,
    output logic [GHR_DEPTH*33-1:0]       o_globalHistoryRegister_660,
    output logic [WT_ROWS*WT_ROW_W-1:0]   o_weightTable_16416,
    output logic [7:0]                    o_pendingB_8,
    output logic [2:0]                    o_counter_3,
    output logic [31:0]                   o_correctPC,
    output logic                          o_stall,
    output logic                          o_ready,
    output logic                          o_resErr
);

    localparam int ENT_W     = 33;
    localparam int IDX_W     = $clog2(GHR_DEPTH);
    localparam int MAX_PUSH  = 4;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_RECOVER} state_t;
    typedef logic [GHR_DEPTH-1:0][ENT_W-1:0] ghr_t;

    state_t                            state;
    ghr_t                              ghr;
    logic [7:0]                        pending;
    logic [31:0]                       correct_pc;
    logic                              res_err;
    logic [WT_ROWS-1:0][WT_ROW_W-1:0]  wt;

    logic        stall;
    logic        push_go;
    logic [2:0]  push_n;
    logic        res_go;
    logic        oldest_taken;
    logic        res_hit;
    logic        res_miss;
    logic [8:0]  pend_sum;
    logic [7:0]  next_pending;
    logic        wt_we;

    // Entries shift up by n; new entries fill 0..n-1 with entry 0 the youngest.
    function automatic ghr_t push_entries(input ghr_t cur, input logic [131:0] ne, input logic [2:0] n);
        ghr_t r;
        for (int j = 0; j < GHR_DEPTH; j++) begin
            if (j >= int'(n))
                r[j] = cur[IDX_W'(j - int'(n))];
            else
                r[j] = '0;
        end
        for (int k = 0; k < MAX_PUSH; k++) begin
            if (k < int'(n))
                r[k] = ne[k*ENT_W +: ENT_W];
        end
        return r;
    endfunction

    // Drop the younger wrong-path entries so the mispredicted one lands at 0 with its direction corrected.
    function automatic ghr_t flush_entries(input ghr_t cur, input logic [7:0] p);
        ghr_t r;
        int   src;
        for (int j = 0; j < GHR_DEPTH; j++) begin
            src = j + int'(p) - 1;
            if (src >= 0 && src < GHR_DEPTH)
                r[j] = cur[IDX_W'(src)];
            else
                r[j] = '0;
        end
        r[0][0] = ~r[0][0];
        return r;
    endfunction

    assign stall   = (state != S_RUN) | (pending > 8'(GHR_DEPTH - 4));
    assign push_go = (state == S_RUN) & i_predValid & ~stall;
    assign res_go  = (state == S_RUN) & i_resValid & (pending != 8'd0);

    always_comb begin
        push_n = 3'd0;
        if (push_go)
            push_n = (i_passBNum_3 > 3'(MAX_PUSH)) ? 3'(MAX_PUSH) : i_passBNum_3;
    end

    always_comb begin
        oldest_taken = 1'b0;
        if (pending != 8'd0)
            oldest_taken = ghr[IDX_W'(pending - 8'd1)][0];
    end

    assign res_hit  = res_go & (i_resTaken == oldest_taken);
    assign res_miss = res_go & (i_resTaken != oldest_taken);
    assign pend_sum = {1'b0, pending} + 9'(push_n) - 9'(res_hit);

    always_comb begin
        next_pending = pend_sum[7:0];
        if (pend_sum > 9'(GHR_DEPTH))
            next_pending = 8'(GHR_DEPTH);
    end

    assign wt_we = (state == S_RECOVER) & (i_errWeightPos_8 < 8'(WT_ROWS));

`ifdef WEIGHT_INIT_SWEEP_EN
    logic [7:0] init_idx;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_INIT;
            ghr        <= '0;
            pending    <= 8'd0;
            correct_pc <= 32'd0;
            res_err    <= 1'b0;
`ifdef WEIGHT_INIT_SWEEP_EN
            init_idx   <= 8'd0;
`endif
        end else begin
            res_err <= 1'b0;
            case (state)
                S_INIT: begin
`ifdef WEIGHT_INIT_SWEEP_EN
                    init_idx <= init_idx + 8'd1;
                    if (init_idx == 8'(WT_ROWS - 1))
                        state <= S_RUN;
`else
                    state <= S_RUN;
`endif
                end
                S_RUN: begin
                    if (i_resValid && pending == 8'd0)
                        res_err <= 1'b1;
                    if (res_miss) begin
                        correct_pc <= i_resTaken ? i_resTarget_32 : i_resFallPC_32;
                        state      <= S_RECOVER;
                    end else begin
                        if (push_n != 3'd0)
                            ghr <= push_entries(ghr, i_newGHREntry_132, push_n);
                        pending <= next_pending;
                    end
                end
                S_RECOVER: begin
                    ghr        <= flush_entries(ghr, pending);
                    pending    <= 8'd0;
                    correct_pc <= 32'd0;
                    state      <= S_RUN;
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef WEIGHT_INIT_SWEEP_EN
    // Table has no reset; INIT walks it clear and reset parks the FSM in INIT so no late write can slip in.
    always_ff @(posedge i_clk) begin
        if (state == S_INIT)
            wt[init_idx] <= '0;
        else if (wt_we)
            wt[i_errWeightPos_8] <= i_newWeights_72;
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            wt <= '0;
        else if (wt_we)
            wt[i_errWeightPos_8] <= i_newWeights_72;
    end
`endif

    assign o_globalHistoryRegister_660 = ghr;
    assign o_weightTable_16416         = wt;
    assign o_pendingB_8                = pending;
    assign o_counter_3                 = 3'd0;
    assign o_correctPC                 = correct_pc;
    assign o_stall                     = stall;
    assign o_ready                     = (state != S_INIT);
    assign o_resErr                    = res_err;

endmodule

// File: tb/tb_bhistoryresolveunit.sv
// Directed + random bench for bhistoryresolveunit against a queue-based history model.
module tb_bhistoryresolveunit;

    logic           clk = 1'b0;
    logic           rst;
    logic           pred_valid;
    logic [2:0]     pass_n;
    logic [131:0]   new_ent;
    logic [7:0]     err_pos;
    logic [71:0]    new_w;
    logic           res_valid;
    logic           res_taken;
    logic [31:0]    res_target;
    logic [31:0]    res_fall;
    logic [659:0]   ghr_o;
    logic [16415:0] wt_o;
    logic [7:0]     pend_o;
    logic [2:0]     cnt_o;
    logic [31:0]    pc_o;
    logic           stall_o;
    logic           ready_o;
    logic           reserr_o;

    int total = 0;
    int bad   = 0;

`ifdef WEIGHT_INIT_SWEEP_EN
    localparam int EXP_READY = 228;
`else
    localparam int EXP_READY = 1;
`endif

    // Model: youngest-first queue of exactly 20 entries, pending count, redirect PC, recover flag.
    logic [32:0] mq[$];
    int          m_pend;
    logic [31:0] m_pc;
    bit          m_rec;
    bit          m_err;
    logic [71:0] mwt [228];

    always #5 clk = ~clk;

    bhistoryresolveunit dut (
        .i_clk(clk), .i_rst(rst), .i_predValid(pred_valid), .i_passBNum_3(pass_n),
        .i_newGHREntry_132(new_ent), .i_errWeightPos_8(err_pos), .i_newWeights_72(new_w),
        .i_resValid(res_valid), .i_resTaken(res_taken), .i_resTarget_32(res_target),
        .i_resFallPC_32(res_fall), .o_globalHistoryRegister_660(ghr_o),
        .o_weightTable_16416(wt_o), .o_pendingB_8(pend_o), .o_counter_3(cnt_o),
        .o_correctPC(pc_o), .o_stall(stall_o), .o_ready(ready_o), .o_resErr(reserr_o)
    );

    task automatic check(input string tag, input logic [659:0] obs, input logic [659:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [659:0] mflat();
        logic [659:0] f = '0;
        for (int j = 0; j < 20; j++) f[j*33 +: 33] = mq[j];
        return f;
    endfunction

    function automatic logic [131:0] rand_ents();
        logic [131:0] r;
        for (int k = 0; k < 4; k++) r[k*33 +: 33] = {$urandom(), 1'($urandom())};
        return r;
    endfunction

    function automatic bit oldest_bit();
        logic [32:0] e;
        e = mq[m_pend - 1];
        return e[0];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int j = 0; j < 20; j++) mq.push_back(33'd0);
        m_pend = 0; m_pc = 0; m_rec = 0; m_err = 0;
        for (int r = 0; r < 228; r++) mwt[r] = '0;
    endtask

    task automatic check_table(input string tag);
        for (int r = 0; r < 228; r++)
            check($sformatf("%s_row%0d", tag, r), 660'(wt_o[r*72 +: 72]), 660'(mwt[r]));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ghr"},     ghr_o, mflat());
        check({tag, "_pending"}, 660'(pend_o), 660'(m_pend));
        check({tag, "_pc"},      660'(pc_o), 660'(m_pc));
        check({tag, "_stall"},   660'(stall_o), 660'(m_rec || m_pend > 16));
        check({tag, "_reserr"},  660'(reserr_o), 660'(m_err));
        check({tag, "_ready"},   660'(ready_o), 660'(1));
        check({tag, "_counter"}, 660'(cnt_o), 660'(0));
    endtask

    // One clock: drive, advance past the edge, evolve the model, compare.
    task automatic step(input string tag, input bit pv, input logic [2:0] n, input logic [131:0] ent,
                        input logic [7:0] ewp, input logic [71:0] nw, input bit rv, input bit rt,
                        input logic [31:0] tgt, input logic [31:0] fall);
        int          nn;
        bit          hit;
        logic [32:0] e;
        pred_valid = pv; pass_n = n; new_ent = ent; err_pos = ewp; new_w = nw;
        res_valid = rv; res_taken = rt; res_target = tgt; res_fall = fall;
        @(posedge clk); #1;
        if (m_rec) begin
            if (ewp < 8'd228) mwt[ewp] = nw;
            for (int i = 0; i < m_pend - 1; i++) begin
                void'(mq.pop_front());
                mq.push_back(33'd0);
            end
            e = mq[0]; e[0] = ~e[0]; mq[0] = e;
            m_pend = 0; m_pc = 0; m_rec = 0; m_err = 0;
        end else begin
            nn = (pv && m_pend <= 16) ? int'(n) : 0;
            m_err = rv && (m_pend == 0);
            hit = 0;
            if (rv && m_pend > 0 && rt != oldest_bit()) begin
                m_pc = rt ? tgt : fall;
                m_rec = 1;
            end else begin
                hit = rv && (m_pend > 0);
                for (int k = nn - 1; k >= 0; k--) begin
                    mq.push_front(ent[k*33 +: 33]);
                    void'(mq.pop_back());
                end
                m_pend = m_pend + nn - int'(hit);
            end
        end
        check_outputs(tag);
    endtask

    task automatic push(input string tag, input logic [2:0] n, input logic [131:0] ent);
        step(tag, 1, n, ent, 8'hFF, '0, 0, 0, 0, 0);
    endtask

    task automatic resolve_ok(input string tag);
        step(tag, 0, 0, '0, 8'hFF, '0, 1, oldest_bit(), 32'h4000, 32'h4004);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, '0, 8'hFF, '0, 0, 0, 0, 0);
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!ready_o && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_cycles"}, 660'(cyc), 660'(EXP_READY));
        check({tag, "_stall"}, 660'(stall_o), 660'(0));
    endtask

    initial begin
        logic [32:0]  a, b, c, d, e, f, x, y, z;
        logic [131:0] ent;
        logic [71:0]  w5, w7;
        bit           ob;

        rst = 1; pred_valid = 0; pass_n = 0; new_ent = '0; err_pos = 8'hFF; new_w = '0;
        res_valid = 0; res_taken = 0; res_target = 0; res_fall = 0;
        model_reset();
        #23;
        check("rst_ghr", ghr_o, '0);
        check("rst_pending", 660'(pend_o), 660'(0));
        check("rst_pc", 660'(pc_o), 660'(0));
        check("rst_stall", 660'(stall_o), 660'(1));
        check("rst_reserr", 660'(reserr_o), 660'(0));
        check("rst_ready", 660'(ready_o), 660'(0));
        @(posedge clk); #1;
        rst = 0;
        wait_ready("init");
        check_table("init");

        // Two pushes in program order A,B,C then D,E; entry 0 of each group is its youngest.
        a = {$urandom(), 1'b1}; b = {$urandom(), 1'b0}; c = {$urandom(), 1'b1};
        d = {$urandom(), 1'b0}; e = {$urandom(), 1'b1};
        push("push3", 3'd3, {33'd0, a, b, c});
        push("push2", 3'd2, {33'd0, 33'd0, d, e});
        check("order", 660'(ghr_o[164:0]), 660'({a, b, c, d, e}));
        check("pend5", 660'(pend_o), 660'(5));

        resolve_ok("res_a"); resolve_ok("res_b"); resolve_ok("res_c");
        f = {$urandom(), 1'b0};
        step("res_push", 1, 3'd1, {99'd0, f}, 8'hFF, '0, 1, oldest_bit(), 32'h10, 32'h14);
        check("res_push_pend", 660'(pend_o), 660'(2));
        check("res_push_ghr0", 660'(ghr_o[32:0]), 660'(f));
        check("res_push_ghr1", 660'(ghr_o[65:33]), 660'(e));
        resolve_ok("drain1"); resolve_ok("drain2");

        // Mispredict on the oldest of three, with a push in the same cycle that must be discarded.
        x = {$urandom(), 1'b0}; y = {$urandom(), 1'b1}; z = {$urandom(), 1'b0};
        push("push_xyz", 3'd3, {33'd0, x, y, z});
        step("mispred", 1, 3'd2, rand_ents(), 8'hFF, '0, 1, 1, 32'h1000, 32'h2000);
        check("mispred_pc", 660'(pc_o), 660'(32'h1000));
        check("mispred_pend", 660'(pend_o), 660'(3));
        w5 = {$urandom(), $urandom(), 8'hA5};
        step("recover", 1, 3'd4, rand_ents(), 8'd5, w5, 1, 0, 32'h1, 32'h1);
        check("recover_ghr0", 660'(ghr_o[32:0]), 660'({x[32:1], 1'b1}));
        check("recover_row5", 660'(wt_o[5*72 +: 72]), 660'(w5));
        check_table("after_w5");

        push("push_one", 3'd1, rand_ents());
        step("mispred2", 0, 0, '0, 8'hFF, '0, 1, ~oldest_bit(), 32'h3000, 32'h3004);
        step("recover_oob", 0, 0, '0, 8'd228, {$urandom(), $urandom(), 8'h11}, 0, 0, 0, 0);
        check_table("oob");

        // Fill to 17 then a stalled push must be ignored.
        for (int i = 0; i < 4; i++) push("fill4", 3'd4, rand_ents());
        push("fill1", 3'd1, rand_ents());
        check("stall17", 660'(stall_o), 660'(1));
        push("stalled_push", 3'd4, rand_ents());
        check("pend17", 660'(pend_o), 660'(17));
        for (int i = 0; i < 17; i++) resolve_ok("drain17");
        step("res_empty", 0, 0, '0, 8'hFF, '0, 1, 1, 32'h50, 32'h54);
        check("reserr_pulse", 660'(reserr_o), 660'(1));
        idle("reserr_clear");

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom()), 3'($urandom_range(0, 4)), rand_ents(),
                 8'($urandom_range(0, 255)), {$urandom(), $urandom(), 8'($urandom())},
                 ($urandom_range(0, 2) == 0), 1'($urandom()),
                 $urandom() | 32'h1, $urandom() | 32'h1);
        end
        if (m_rec) idle("rand_tail");
        check_table("rand");

        // Reset landing inside RECOVER must suppress the pending row write.
        push("pre_rst", 3'd1, rand_ents());
        ob = oldest_bit();
        step("pre_rst_mis", 0, 0, '0, 8'hFF, '0, 1, ~ob, 32'h6000, 32'h6004);
        w7 = {$urandom() | 32'h1, $urandom(), 8'h77};
        err_pos = 8'd7; new_w = w7; res_valid = 0;
        #2 rst = 1;
        @(posedge clk); #1;
        rst = 0; err_pos = 8'hFF;
        model_reset();
        wait_ready("rst2");
        check("rst2_row7", 660'(wt_o[7*72 +: 72]), 660'(0));
        idle("rst2_idle");
        check_table("rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
